// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front end: frame geometry and sample/frame types.
// The FFT_Processor side imports this same package so both ends agree on sizes.
package fft_pkg;

    localparam int N_POINTS = 16;
    localparam int DATA_W   = 16;
    localparam int CNT_W    = $clog2(N_POINTS) + 1;
    localparam int IDX_W    = $clog2(N_POINTS);

    typedef logic [DATA_W-1:0]    sample_t;
    typedef sample_t [N_POINTS-1:0] frame_t;
    typedef logic [CNT_W-1:0]     cnt_t;

endpackage

// File: rtl/fft_sample_bank.sv
// One ping-pong bank: N_POINTS sample slots plus a fill count.
// The owner supplies the slot to write; the count tracks one past the last slot written
// so it reaches N_POINTS exactly when the bank is full and never wraps.
module fft_sample_bank
    import fft_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_we,
    input  cnt_t    i_slot,
    input  sample_t i_data,
    input  logic    i_clr,
    output frame_t  o_frame,
    output cnt_t    o_cnt,
    output logic    o_full
);

    cnt_t   r_cnt;
    frame_t r_frame;
    logic   w_slot_ok;

    assign w_slot_ok = (i_slot < cnt_t'(N_POINTS));

    // Sample storage; contents are meaningless until written, so no reset term
    always_ff @(posedge i_clk) begin
        if (i_we && w_slot_ok) begin
            r_frame[i_slot[IDX_W-1:0]] <= i_data;
        end
    end

    // Fill count: a write leaves it one past the written slot, a clear restarts the bank
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_we && w_slot_ok) begin
            r_cnt <= i_slot + cnt_t'(1);
        end else if (i_clr) begin
            r_cnt <= '0;
        end
    end

    assign o_frame = r_frame;
    assign o_cnt   = r_cnt;
    assign o_full  = (r_cnt == cnt_t'(N_POINTS));

endmodule

// File: rtl/fft_frame_collector.sv
// Collects a serial sample stream into frames using two banks, launches each full frame
// to the FFT with a one-cycle new_t pulse and holds it on frame_out until done.
// Optional feature macro: FFT_DROP_COUNT_EN adds a saturating o_drop_count port.
module fft_frame_collector
    import fft_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_sample_valid,
    input  sample_t                    i_sample_in,
    input  logic                       i_fft_done,
    output logic [N_POINTS*DATA_W-1:0] o_frame_out,
    output logic                       o_new_t,
    output logic                       o_fft_busy,
    output logic                       o_overflow
`ifdef FFT_DROP_COUNT_EN
    ,
    output logic [15:0]                o_drop_count
`endif
);

    logic   r_sel;
    logic   r_busy;
    logic   r_new_t;
    frame_t r_frame;

    frame_t w_frame0;
    frame_t w_frame1;
    cnt_t   w_cnt0;
    cnt_t   w_cnt1;
    logic   w_full0;
    logic   w_full1;

    frame_t w_wr_frame;
    cnt_t   w_wr_cnt;
    logic   w_wr_full;
    logic   w_launch;
    logic   w_accept;
    logic   w_drop;
    logic   w_tgt;
    cnt_t   w_slot;

    assign w_wr_frame = r_sel ? w_frame1 : w_frame0;
    assign w_wr_cnt   = r_sel ? w_cnt1   : w_cnt0;
    assign w_wr_full  = r_sel ? w_full1  : w_full0;

    // A launch swaps banks, so a sample arriving on that edge goes to slot 0 of the other bank
    assign w_launch = w_wr_full & ~r_busy;
    assign w_accept = i_sample_valid & (w_launch | ~w_wr_full);
    assign w_drop   = i_sample_valid & w_wr_full & ~w_launch;
    assign w_tgt    = r_sel ^ w_launch;
    assign w_slot   = w_launch ? '0 : w_wr_cnt;

    fft_sample_bank u_bank0 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_accept & ~w_tgt),
        .i_slot  (w_slot),
        .i_data  (i_sample_in),
        .i_clr   (w_launch & r_sel),
        .o_frame (w_frame0),
        .o_cnt   (w_cnt0),
        .o_full  (w_full0)
    );

    fft_sample_bank u_bank1 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_accept & w_tgt),
        .i_slot  (w_slot),
        .i_data  (i_sample_in),
        .i_clr   (w_launch & ~r_sel),
        .o_frame (w_frame1),
        .o_cnt   (w_cnt1),
        .o_full  (w_full1)
    );

    // Launch control: bank swap, frame capture, launch pulse and busy tracking
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sel   <= 1'b0;
            r_busy  <= 1'b0;
            r_new_t <= 1'b0;
            r_frame <= '0;
        end else begin
            r_new_t <= w_launch;
            if (w_launch) begin
                r_sel   <= ~r_sel;
                r_busy  <= 1'b1;
                r_frame <= w_wr_frame;
            end else if (r_busy && i_fft_done) begin
                r_busy <= 1'b0;
            end
        end
    end

`ifdef FFT_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    // Dropped-sample counter, saturating so it never falls back to zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_drop_count <= 16'd0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign o_drop_count = r_drop_count;
    assign o_overflow   = (r_drop_count != 16'd0);
`else
    logic r_overflow;

    // Sticky flag recording that at least one sample was dropped
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_overflow = r_overflow;
`endif

    assign o_frame_out = r_frame;
    assign o_new_t     = r_new_t;
    assign o_fft_busy  = r_busy;

endmodule

// File: tb/tb_fft_frame_collector.sv
// Testbench for fft_frame_collector: directed scenarios with random sample data plus a
// randomized run against a queue-based reference model of the frame collector.
// Honours FFT_DROP_COUNT_EN by also checking o_drop_count when the macro is defined.
module tb_fft_frame_collector;
    import fft_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       valid;
    sample_t                    din;
    logic                       done;
    logic [N_POINTS*DATA_W-1:0] frameOut;
    logic                       newT;
    logic                       busy;
    logic                       ovf;
`ifdef FFT_DROP_COUNT_EN
    logic [15:0]                dropCount;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state: pending samples of the filling frame, presented frame, flags
    sample_t                    mQueue[$];
    logic [N_POINTS*DATA_W-1:0] mFrame;
    logic                       mBusy;
    logic                       mNewT;
    logic                       mOvf;
    int                         mDrops;

    fft_frame_collector dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_sample_valid (valid),
        .i_sample_in    (din),
        .i_fft_done     (done),
        .o_frame_out    (frameOut),
        .o_new_t        (newT),
        .o_fft_busy     (busy),
        .o_overflow     (ovf)
`ifdef FFT_DROP_COUNT_EN
        ,
        .o_drop_count   (dropCount)
`endif
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    task automatic resetModel();
        mQueue.delete();
        mFrame = '0;
        mBusy  = 1'b0;
        mNewT  = 1'b0;
        mOvf   = 1'b0;
        mDrops = 0;
    endtask

    task automatic applyReset();
        rst   = 1'b1;
        valid = 1'b0;
        din   = '0;
        done  = 1'b0;
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, settle past the edge
    task automatic tick(input logic v, input sample_t d, input logic dn);
        logic launch;
        valid = v;
        din   = d;
        done  = dn;
        @(posedge clk);
        launch = (mQueue.size() == N_POINTS) && !mBusy;
        mNewT  = launch;
        if (launch) begin
            for (int k = 0; k < N_POINTS; k++) mFrame[k*DATA_W +: DATA_W] = mQueue[k];
            mQueue.delete();
            mBusy = 1'b1;
            if (v) mQueue.push_back(d);
        end else begin
            if (mBusy && dn) mBusy = 1'b0;
            if (v) begin
                if (mQueue.size() < N_POINTS) begin
                    mQueue.push_back(d);
                end else begin
                    mOvf = 1'b1;
                    if (mDrops < 65535) mDrops++;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        applyReset();
        checks++;
        if ({newT, busy, ovf} !== 3'b000 || frameOut !== '0) begin
            failures++;
            $display("[TB] FAIL reset_initial: got flags=%b frame=%h, expected all zero", {newT, busy, ovf}, frameOut);
        end
        for (int i = 0; i < N_POINTS; i++) tick(1'b1, sample_t'($urandom_range(1, 65535)), 1'b0);
        tick(1'b0, '0, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b1, sample_t'($urandom), 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_prearm_busy: got %b expected 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({newT, busy, ovf} !== 3'b000 || frameOut !== '0) begin
            failures++;
            $display("[TB] FAIL reset_async: got flags=%b frame=%h, expected all zero", {newT, busy, ovf}, frameOut);
        end
        resetModel();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N_POINTS; i++) tick(1'b1, sample_t'(i), 1'b0);
        tick(1'b0, '0, 1'b0);
        checks++;
        if (newT !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_relaunch_new_t: got %b expected 1", newT);
        end
        for (int k = 0; k < N_POINTS; k++) begin
            checks++;
            if (frameOut[k*DATA_W +: DATA_W] !== sample_t'(k)) begin
                failures++;
                $display("[TB] FAIL reset_relaunch_t%0d: got %0d expected %0d", k, frameOut[k*DATA_W +: DATA_W], k);
            end
        end
    endtask

    task automatic test_single_frame();
        applyReset();
        for (int i = 0; i < N_POINTS; i++) tick(1'b1, (i % 2 == 0) ? sample_t'(10) : sample_t'(0), 1'b0);
        checks++;
        if (newT !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_early_new_t: got %b expected 0", newT);
        end
        tick(1'b0, '0, 1'b0);
        checks++;
        if (newT !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_launch: got new_t=%b busy=%b expected 1 1", newT, busy);
        end
        for (int k = 0; k < N_POINTS; k++) begin
            checks++;
            if (frameOut[k*DATA_W +: DATA_W] !== ((k % 2 == 0) ? sample_t'(10) : sample_t'(0))) begin
                failures++;
                $display("[TB] FAIL single_t%0d: got %0d expected %0d", k, frameOut[k*DATA_W +: DATA_W], (k % 2 == 0) ? 10 : 0);
            end
        end
        tick(1'b0, '0, 1'b0);
        checks++;
        if (newT !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_pulse_width: got new_t=%b busy=%b expected 0 1", newT, busy);
        end
    endtask

    task automatic test_overlap();
        sample_t first[N_POINTS];
        logic [N_POINTS*DATA_W-1:0] firstFrame;
        applyReset();
        for (int i = 0; i < N_POINTS; i++) begin
            first[i] = sample_t'($urandom);
            firstFrame[i*DATA_W +: DATA_W] = first[i];
            tick(1'b1, first[i], 1'b0);
        end
        tick(1'b0, '0, 1'b0);
        checks++;
        if (newT !== 1'b1 || frameOut !== firstFrame) begin
            failures++;
            $display("[TB] FAIL overlap_first_launch: got new_t=%b frame=%h expected 1 %h", newT, frameOut, firstFrame);
        end
        for (int i = 0; i < N_POINTS + 5; i++) begin
            tick(i < N_POINTS, sample_t'(100 + i), 1'b0);
            checks++;
            if (newT !== 1'b0 || busy !== 1'b1 || frameOut !== firstFrame) begin
                failures++;
                $display("[TB] FAIL overlap_hold_%0d: got new_t=%b busy=%b frame=%h expected 0 1 %h", i, newT, busy, frameOut, firstFrame);
            end
        end
        tick(1'b0, '0, 1'b1);
        checks++;
        if (busy !== 1'b0 || newT !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overlap_done: got busy=%b new_t=%b expected 0 0", busy, newT);
        end
        tick(1'b0, '0, 1'b0);
        checks++;
        if (newT !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overlap_second_launch: got new_t=%b busy=%b expected 1 1", newT, busy);
        end
        for (int k = 0; k < N_POINTS; k++) begin
            checks++;
            if (frameOut[k*DATA_W +: DATA_W] !== sample_t'(100 + k)) begin
                failures++;
                $display("[TB] FAIL overlap_t%0d: got %0d expected %0d", k, frameOut[k*DATA_W +: DATA_W], 100 + k);
            end
        end
    endtask

    task automatic test_overflow();
        sample_t second[N_POINTS];
        applyReset();
        for (int i = 0; i < N_POINTS; i++) tick(1'b1, sample_t'($urandom), 1'b0);
        tick(1'b0, '0, 1'b0);
        for (int i = 0; i < N_POINTS; i++) begin
            second[i] = sample_t'($urandom);
            tick(1'b1, second[i], 1'b0);
        end
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overflow_before: got %b expected 0", ovf);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, sample_t'($urandom), 1'b0);
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overflow_flag: got %b expected 1", ovf);
        end
`ifdef FFT_DROP_COUNT_EN
        checks++;
        if (dropCount !== 16'd3) begin
            failures++;
            $display("[TB] FAIL overflow_drop_count: got %0d expected 3", dropCount);
        end
`endif
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b0);
        checks++;
        if (newT !== 1'b1 || ovf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overflow_relaunch: got new_t=%b overflow=%b expected 1 1", newT, ovf);
        end
        for (int k = 0; k < N_POINTS; k++) begin
            checks++;
            if (frameOut[k*DATA_W +: DATA_W] !== second[k]) begin
                failures++;
                $display("[TB] FAIL overflow_t%0d: got %0h expected %0h", k, frameOut[k*DATA_W +: DATA_W], second[k]);
            end
        end
    endtask

    task automatic test_coincidence();
        sample_t second[N_POINTS];
        sample_t third[N_POINTS];
        sample_t launchSample;
        applyReset();
        for (int i = 0; i < N_POINTS; i++) tick(1'b1, sample_t'($urandom), 1'b0);
        tick(1'b0, '0, 1'b0);
        for (int i = 0; i < N_POINTS; i++) second[i] = sample_t'($urandom);
        for (int i = 0; i < N_POINTS - 1; i++) tick(1'b1, second[i], 1'b0);
        tick(1'b1, second[N_POINTS-1], 1'b1);
        checks++;
        if (busy !== 1'b0 || newT !== 1'b0) begin
            failures++;
            $display("[TB] FAIL coinc_same_edge: got busy=%b new_t=%b expected 0 0", busy, newT);
        end
        launchSample = sample_t'($urandom);
        tick(1'b1, launchSample, 1'b0);
        checks++;
        if (newT !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL coinc_launch: got new_t=%b busy=%b expected 1 1", newT, busy);
        end
        for (int k = 0; k < N_POINTS; k++) begin
            checks++;
            if (frameOut[k*DATA_W +: DATA_W] !== second[k]) begin
                failures++;
                $display("[TB] FAIL coinc_t%0d: got %0h expected %0h", k, frameOut[k*DATA_W +: DATA_W], second[k]);
            end
        end
        third[0] = launchSample;
        for (int i = 1; i < N_POINTS; i++) begin
            third[i] = sample_t'($urandom);
            tick(1'b1, third[i], 1'b0);
        end
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b0);
        checks++;
        if (newT !== 1'b1) begin
            failures++;
            $display("[TB] FAIL coinc_third_launch: got %b expected 1", newT);
        end
        for (int k = 0; k < N_POINTS; k++) begin
            checks++;
            if (frameOut[k*DATA_W +: DATA_W] !== third[k]) begin
                failures++;
                $display("[TB] FAIL coinc_third_t%0d: got %0h expected %0h", k, frameOut[k*DATA_W +: DATA_W], third[k]);
            end
        end
    endtask

    task automatic test_spurious_done();
        applyReset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, 1'b1);
            checks++;
            if ({newT, busy, ovf} !== 3'b000 || frameOut !== '0) begin
                failures++;
                $display("[TB] FAIL spurious_idle_%0d: got flags=%b frame=%h expected all zero", i, {newT, busy, ovf}, frameOut);
            end
        end
        for (int i = 0; i < N_POINTS; i++) tick(1'b1, sample_t'(i + 1), 1'b1);
        checks++;
        if (newT !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL spurious_fill: got new_t=%b busy=%b expected 0 0", newT, busy);
        end
        tick(1'b0, '0, 1'b1);
        checks++;
        if (newT !== 1'b1 || busy !== 1'b1 || frameOut[DATA_W-1:0] !== sample_t'(1)) begin
            failures++;
            $display("[TB] FAIL spurious_launch: got new_t=%b busy=%b t0=%0d expected 1 1 1", newT, busy, frameOut[DATA_W-1:0]);
        end
    endtask

    task automatic test_random();
        int doneRate;
        applyReset();
        for (int c = 0; c < 600; c++) begin
            doneRate = (c < 300) ? 25 : 3;
            tick($urandom_range(0, 99) < 70, sample_t'($urandom), $urandom_range(0, 99) < doneRate);
            checks++;
            if (newT !== mNewT || busy !== mBusy || ovf !== mOvf || frameOut !== mFrame) begin
                failures++;
                $display("[TB] FAIL random_cycle_%0d: got new_t=%b busy=%b ovf=%b frame=%h expected %b %b %b %h",
                         c, newT, busy, ovf, frameOut, mNewT, mBusy, mOvf, mFrame);
            end
`ifdef FFT_DROP_COUNT_EN
            checks++;
            if (dropCount !== 16'(mDrops)) begin
                failures++;
                $display("[TB] FAIL random_drop_count_%0d: got %0d expected %0d", c, dropCount, mDrops);
            end
`endif
        end
    endtask

    // Scenario sequence and final summary
    initial begin
        test_reset();
        test_single_frame();
        test_overlap();
        test_overflow();
        test_coincidence();
        test_spurious_done();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
